zeroriscy_ex_mc_seq: RTL and testbench
======================================

# zeroriscy_ex_mc_seq

Parametrised multi-cycle sequencer for the execute stage. It generalises the fixed multdiv/mmult/LSU ready-and-result muxing to NUM_UNITS multi-cycle units. It issues one-cycle start pulses, tracks the single outstanding operation, and captures the unit result into a register. It adds flush abort, a timeout watchdog and detection of conflicting enables. It sits between the ID-stage enables and the multi-cycle units, and drives the EX-stage ready and writeback data.

## Interface
- NUM_UNITS, 3: number of multi-cycle units (1..8).
- DATA_WIDTH, 32: result width.
- TIMEOUT_CYCLES, 64: RUN-state watchdog limit; 0 disables the watchdog.
- IDX_W, $clog2(NUM_UNITS) (minimum 1): width of the latched unit index (derived).

- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en_i  in  NUM_UNITS  request from ID; level, one-hot expected; held until ex_ready_o.
- flush_i  in  1  abort the current operation (controller kill).
- alu_result_i  in  DATA_WIDTH  single-cycle ALU result.
- unit_ready_i  in  NUM_UNITS  unit done; sampled only for the latched unit in RUN.
- unit_result_i  in  NUM_UNITS*DATA_WIDTH  unit k result at bits [k*DATA_WIDTH +: DATA_WIDTH].
- unit_start_o  out  NUM_UNITS  one-cycle start pulse to the selected unit.
- result_o  out  DATA_WIDTH  writeback data.
- ex_ready_o  out  1  EX stage accepts the next instruction.
- busy_o  out  1  operation outstanding (state RUN).
- timeout_o  out  1  one-cycle pulse when the watchdog fires.
- sel_err_o  out  1  more than one en_i bit is set while in IDLE.

## Operation
- States: IDLE, RUN, DONE. Registers: state, idx_q, result_q, cnt_q.
- IDLE, en_i == 0:
  - ex_ready_o = 1; result_o = alu_result_i (combinational).
  - unit_start_o = 0; state is held.
- IDLE, en_i != 0:
  - k = lowest set bit of en_i. unit_start_o[k] = 1 this cycle.
  - Latch idx_q <= k and cnt_q <= 0; next state RUN.
  - ex_ready_o = 0.
  - sel_err_o = 1 if popcount(en_i) > 1. Lowest index still wins.
- RUN:
  - busy_o = 1; ex_ready_o = 0; unit_start_o = 0. Changes on en_i are ignored.
  - If unit_ready_i[idx_q] = 1: result_q <= unit_result_i slice idx_q; next state DONE.
  - Else cnt_q <= cnt_q + 1.
  - If TIMEOUT_CYCLES != 0 and cnt_q == TIMEOUT_CYCLES-1 with ready still low:
    - result_q <= 0; timeout_o = 1 that cycle; next state DONE.
  - unit_ready_i of non-selected units is ignored.
  - cnt_q saturates at TIMEOUT_CYCLES-1 when the watchdog is disabled, with no wrap.
- DONE: ex_ready_o = 1; result_o = result_q; next state IDLE unconditionally.
- Flush, any state: flush_i = 1 forces next state IDLE.
  - In that cycle, unit_start_o = 0 and ex_ready_o = 0.
  - result_q and cnt_q are not updated.
  - A ready arriving in the same cycle is discarded.
  - Flush has priority over ready and over timeout.
- Ready and timeout in the same cycle: ready wins; timeout_o = 0; the real result is captured.

## Timing
- While rst = 1, the next state is IDLE, result_q = 0, cnt_q = 0, idx_q = 0.
- While rst = 1, outputs are: unit_start_o = 0, ex_ready_o = 0, busy_o = 0, timeout_o = 0, sel_err_o = 0, result_o = 0.
- ALU-only instruction: 0 extra cycles; ex_ready_o is high in the same cycle.
- Multi-cycle operation:
  - Start pulse in cycle 0 (IDLE).
  - Earliest ready sample in cycle 1 (RUN).
  - ex_ready_o and result in the cycle after ready is seen.
  - Minimum total is 3 cycles (cycle 0 to cycle 2).
- Unit latency L: unit_ready_i high in cycle L ≥ 1 gives ex_ready_o in cycle L+1.
- Timeout: timeout_o high in cycle TIMEOUT_CYCLES; ex_ready_o high in cycle TIMEOUT_CYCLES+1.
- Back-to-back requests: ID presents a new en_i in the cycle after DONE. Its start pulse is issued in that IDLE cycle, with no bubble beyond the DONE cycle.
- unit_start_o is never high for two consecutive cycles.

## Test plan
- ALU path: en_i = 0, alu_result_i = 0x1234_5678 → ex_ready_o = 1 and result_o = 0x1234_5678 in the same cycle; unit_start_o = 0.
- Unit 1, latency 4:
  - en_i = 3'b010 at cycle 0 → unit_start_o = 3'b010 at cycle 0 only; busy_o high in cycles 1-4.
  - unit_ready_i[1] high at cycle 4 with result 0xDEAD_BEEF → ex_ready_o = 1 and result_o = 0xDEAD_BEEF at cycle 5.
- Conflicting enables: en_i = 3'b110 → sel_err_o = 1 and unit_start_o = 3'b010.
  - unit_ready_i[2] toggling in RUN has no effect; completion waits for unit_ready_i[1].
- Timeout, TIMEOUT_CYCLES = 8, ready never asserted:
  - timeout_o pulses at cycle 8.
  - ex_ready_o = 1 and result_o = 0 at cycle 9.
  - A simultaneous ready and timeout at cycle 8 → timeout_o = 0 and the real result is returned.
- Flush in RUN at cycle 3, with ready also high at cycle 3 → no ex_ready_o.
  - State is IDLE at cycle 4; result_q is unchanged.
  - A new en_i = 3'b001 at cycle 4 → start pulse at cycle 4.
- Reset mid-RUN: rst = 1 at cycle 2 → IDLE and all outputs 0 during reset.
  - After release with en_i = 0 → ex_ready_o = 1 and no stale start pulse.

Source files
------------

// File: rtl/zeroriscy_ex_mc_seq_if.sv
// Handshake/data bundle between ID/EX control, the multi-cycle units and the sequencer.
// Latency: none, this is wiring only.
// Backpressure: ex_ready_o stalls ID; en_i is held by ID until ex_ready_o.
interface zeroriscy_ex_mc_seq_if #(
  parameter int NUM_UNITS  = 3,
  parameter int DATA_WIDTH = 32
);
  // ID-stage side
  logic [NUM_UNITS-1:0]            en_i;
  logic                            flush_i;
  logic [DATA_WIDTH-1:0]           alu_result_i;
  // multi-cycle unit side
  logic [NUM_UNITS-1:0]            unit_ready_i;
  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result_i;
  logic [NUM_UNITS-1:0]            unit_start_o;
  // EX-stage results and status
  logic [DATA_WIDTH-1:0]           result_o;
  logic                            ex_ready_o;
  logic                            busy_o;
  logic                            timeout_o;
  logic                            sel_err_o;

  // Environment that drives requests and unit responses
  modport master (
    output en_i, flush_i, alu_result_i, unit_ready_i, unit_result_i,
    input  unit_start_o, result_o, ex_ready_o, busy_o, timeout_o, sel_err_o
  );

  // The sequencer itself
  modport slave (
    input  en_i, flush_i, alu_result_i, unit_ready_i, unit_result_i,
    output unit_start_o, result_o, ex_ready_o, busy_o, timeout_o, sel_err_o
  );
endinterface

// File: rtl/zeroriscy_ex_mc_seq.sv
// EX-stage sequencer: one outstanding op across NUM_UNITS multi-cycle units, with flush and watchdog.
// Latency: ALU ops 0 cycles; unit op ready at cycle L gives ex_ready_o at L+1 (min 3 cycles total).
// Backpressure: ex_ready_o low while an op is outstanding; flush_i aborts to IDLE with no writeback.
module zeroriscy_ex_mc_seq #(
  parameter int NUM_UNITS      = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int IDX_W          = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input logic                  clk,
  input logic                  rst,
  zeroriscy_ex_mc_seq_if.slave bus
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; with the watchdog off it saturates at all-ones.
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [DATA_WIDTH-1:0] unit_res [NUM_UNITS];
  logic [IDX_W-1:0]      pick_idx;
  logic                  any_en;
  logic                  multi_en;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_result;
  logic                  wdog_hit;

  logic [NUM_UNITS-1:0]  unit_start;
  logic [DATA_WIDTH-1:0] result;
  logic                  ex_ready;
  logic                  busy;
  logic                  timeout;
  logic                  sel_err;

  // Split the flat result bus into per-unit words
  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
    assign unit_res[g] = bus.unit_result_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Lowest set enable wins; scan from the top so the lowest index is written last
  always_comb begin
    pick_idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (bus.en_i[i]) pick_idx = IDX_W'(i);
    end
  end

  assign any_en   = |bus.en_i;
  // Clearing the lowest set bit leaves something only if two or more bits were set
  assign multi_en = (bus.en_i & (bus.en_i - NUM_UNITS'(1))) != '0;

  // Only the latched unit's handshake matters while running
  assign sel_ready  = bus.unit_ready_i[idx_q];
  assign sel_result = unit_res[idx_q];
  assign wdog_hit   = WDOG_EN && (cnt_q == CNT_LAST) && !sel_ready;

  // Sequencer state, latched unit index, captured result and watchdog counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else if (bus.flush_i) begin
      // Abort wins over ready and timeout; result and counter are left untouched
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_en) begin
            idx_q   <= pick_idx;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (sel_ready) begin
            result_q <= sel_result;
            state_q  <= DONE;
          end else if (wdog_hit) begin
            result_q <= '0;
            state_q  <= DONE;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs follow the current state; everything is forced low while in reset
  always_comb begin
    unit_start = '0;
    result     = '0;
    ex_ready   = 1'b0;
    busy       = 1'b0;
    timeout    = 1'b0;
    sel_err    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          result  = bus.alu_result_i;
          sel_err = multi_en;
          if (!bus.flush_i) begin
            if (any_en) begin
              unit_start = NUM_UNITS'(1) << pick_idx;
            end else begin
              ex_ready = 1'b1;
            end
          end
        end
        RUN: begin
          busy    = 1'b1;
          timeout = wdog_hit && !bus.flush_i;
        end
        DONE: begin
          result   = result_q;
          ex_ready = !bus.flush_i;
        end
        default: begin
          result = '0;
        end
      endcase
    end
  end

  assign bus.unit_start_o = unit_start;
  assign bus.result_o     = result;
  assign bus.ex_ready_o   = ex_ready;
  assign bus.busy_o       = busy;
  assign bus.timeout_o    = timeout;
  assign bus.sel_err_o    = sel_err;

endmodule

// File: tb/tb_zeroriscy_ex_mc_seq.sv
// Randomized bench for zeroriscy_ex_mc_seq against a per-operation timeline model.
// Latency: checks every cycle of each operation at the falling edge.
// Backpressure: new requests are presented only after the model's completion/abort cycle.
module tb_zeroriscy_ex_mc_seq;
  localparam int NU = 3;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  zeroriscy_ex_mc_seq_if #(.NUM_UNITS(NU), .DATA_WIDTH(DW)) bus ();

  zeroriscy_ex_mc_seq #(
    .NUM_UNITS(NU),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [2:0] en);
    for (int i = 0; i < NU; i++) if (en[i]) return i;
    return 0;
  endfunction

  task automatic check_ctrl(input string tag, input logic [2:0] start, input bit rdy,
                            input bit bsy, input bit tmo, input bit serr);
    check({tag, " start"},   32'(bus.unit_start_o), 32'(start));
    check({tag, " ready"},   32'(bus.ex_ready_o),   32'(rdy));
    check({tag, " busy"},    32'(bus.busy_o),       32'(bsy));
    check({tag, " timeout"}, 32'(bus.timeout_o),    32'(tmo));
    check({tag, " sel_err"}, 32'(bus.sel_err_o),    32'(serr));
  endtask

  // One IDLE cycle with no request: the ALU result passes straight through
  task automatic idle_cycle(input logic [31:0] alu);
    bus.en_i          = '0;
    bus.flush_i       = 1'b0;
    bus.alu_result_i  = alu;
    bus.unit_ready_i  = 3'($urandom);
    bus.unit_result_i = {$urandom, $urandom, $urandom};
    @(negedge clk);
    check_ctrl("idle", 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("idle result", bus.result_o, alu);
    next_cycle();
  endtask

  // One multi-cycle request. lat = cycle the selected unit raises ready (>TO: never);
  // flush_at = cycle flush is raised (0: no flush). Expected timeline derived from the rules.
  task automatic run_op(input logic [2:0] en, input int lat, input logic [31:0] res,
                        input int flush_at);
    int  k;
    int  done_cyc;
    int  last;
    bit  timed_out;
    bit  flushed;
    k         = lowest(en);
    timed_out = (lat > TO);
    done_cyc  = timed_out ? TO + 1 : lat + 1;
    flushed   = (flush_at >= 1) && (flush_at <= done_cyc);
    last      = flushed ? flush_at : done_cyc;
    for (int c = 0; c <= last; c++) begin
      logic [2:0]  rdy;
      logic [95:0] ures;
      logic [2:0]  onehot;
      bit          fl;
      fl                = flushed && (c == flush_at);
      bus.en_i          = (c == 0) ? en : 3'($urandom);
      bus.flush_i       = fl;
      bus.alu_result_i  = $urandom;
      rdy               = 3'($urandom);
      rdy[k]            = !timed_out && (c == lat);
      bus.unit_ready_i  = rdy;
      ures              = {$urandom, $urandom, $urandom};
      if (c == lat) ures[k*32 +: 32] = res;
      bus.unit_result_i = ures;
      @(negedge clk);
      onehot = 3'b000;
      onehot[k] = 1'b1;
      if (c == 0) begin
        check_ctrl($sformatf("op c0 en=%b", en), onehot, 1'b0, 1'b0, 1'b0,
                   $countones(en) > 1);
      end else if (c < done_cyc) begin
        check_ctrl($sformatf("op run c%0d", c), 3'b000, 1'b0, 1'b1,
                   timed_out && (c == TO) && !fl, 1'b0);
      end else begin
        check_ctrl($sformatf("op done c%0d", c), 3'b000, !fl, 1'b0, 1'b0, 1'b0);
        if (!fl) check($sformatf("op result c%0d", c), bus.result_o,
                       timed_out ? 32'h0 : res);
      end
      next_cycle();
    end
  endtask

  initial begin
    int lat;
    int d;
    int fa;
    rst               = 1'b1;
    bus.en_i          = 3'b010;
    bus.flush_i       = 1'b0;
    bus.alu_result_i  = 32'h1234_5678;
    bus.unit_ready_i  = 3'b111;
    bus.unit_result_i = {$urandom, $urandom, $urandom};
    #1;
    // Reset state: every output low even with a request pending
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_ctrl("reset", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset result", bus.result_o, 32'h0);
      next_cycle();
    end
    rst = 1'b0;

    idle_cycle(32'h1234_5678);
    run_op(3'b010, 4, 32'hDEAD_BEEF, 0);
    run_op(3'b110, 3, 32'hCAFE_F00D, 0);
    run_op(3'b001, 20, 32'h1111_1111, 0);
    run_op(3'b100, TO, 32'h0BAD_F00D, 0);
    run_op(3'b010, 3, 32'h55AA_55AA, 3);
    run_op(3'b001, 2, 32'h7777_0001, 0);
    run_op(3'b100, 20, 32'h0, TO);

    // Flush while IDLE with a request: no start, no ready, stays IDLE
    bus.en_i    = 3'b010;
    bus.flush_i = 1'b1;
    @(negedge clk);
    check_ctrl("idle flush", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    idle_cycle(32'hA5A5_0000);

    // Reset in the middle of a run
    bus.en_i         = 3'b001;
    bus.flush_i      = 1'b0;
    bus.unit_ready_i = 3'b000;
    @(negedge clk);
    check_ctrl("mid c0", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    check_ctrl("mid c1", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_ctrl("mid rst", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid rst result", bus.result_o, 32'h0);
    next_cycle();
    rst = 1'b0;
    idle_cycle(32'h0F0F_F0F0);

    // Randomized operations, back-to-back or separated by ALU cycles
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 2) == 0) idle_cycle($urandom);
      lat = $urandom_range(1, TO + 3);
      d   = (lat > TO) ? TO + 1 : lat + 1;
      fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, d) : 0;
      run_op(3'($urandom_range(1, 7)), lat, $urandom, fa);
    end
    idle_cycle($urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
